// File: rtl/pc_redirect_unit_pkg.sv
// Shared definitions for the PC redirect logic: reset vector, redirect-source
// and FSM state encodings, and the J/JAL target formation helper.
package pc_redirect_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_JMP  = 2'd1,
        SRC_BR   = 2'd2,
        SRC_JR   = 2'd3
    } src_e;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Region-relative jump: upper nibble of PC+4, index, word alignment; no carries.
    function automatic logic [31:0] jump_target(input logic [3:0] pc4_hi,
                                                input logic [25:0] index);
        return {pc4_hi, index, 2'b00};
    endfunction

endpackage

// File: rtl/pc_target_mux.sv
// Combinational redirect request select: JR over branch over jump, jump target
// formation and JR alignment check.
module pc_target_mux
    import pc_redirect_unit_pkg::*;
(
    input  logic        jmp_valid,
    input  logic [25:0] jmp_index,
    input  logic [3:0]  jmp_pc4_hi,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        jr_valid,
    input  logic [31:0] jr_target,
    output logic [31:0] sel_tgt,
    output src_e        sel_src,
    output logic        misalign
);

    always_comb begin
        sel_tgt  = '0;
        sel_src  = SRC_NONE;
        misalign = 1'b0;
        // EX-stage requests are older than the ID-stage jump, so they win.
        if (jr_valid) begin
            sel_tgt  = {jr_target[31:2], 2'b00};
            sel_src  = SRC_JR;
            misalign = |jr_target[1:0];
        end else if (br_valid) begin
            sel_tgt = br_target;
            sel_src = SRC_BR;
        end else if (jmp_valid) begin
            sel_tgt = jump_target(jmp_pc4_hi, jmp_index);
            sel_src = SRC_JMP;
        end
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// Program counter owner: sequential fetch, J/JAL/branch/JR redirects, a
// one-entry pending redirect held across stalls, flush pulse and redirect count.
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             jmp_valid,
    input  logic [25:0]      jmp_index,
    input  logic [3:0]       jmp_pc4_hi,
    input  logic             br_valid,
    input  logic [31:0]      br_target,
    input  logic             jr_valid,
    input  logic [31:0]      jr_target,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             flush,
    output logic             pending,
    output logic             addr_err,
    output logic [CNT_W-1:0] redir_cnt
);

    state_e            state, state_n;
    logic [31:0]       pc_q, pc_n;
    logic [31:0]       pend_tgt, pend_tgt_n;
    src_e              pend_src, pend_src_n;
    logic              pending_q;
    logic              flush_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [31:0]       sel_tgt;
    src_e              sel_src;
    logic              misalign;
    logic              apply;
    logic              take_new;

    pc_target_mux u_mux (
        .jmp_valid  (jmp_valid),
        .jmp_index  (jmp_index),
        .jmp_pc4_hi (jmp_pc4_hi),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .jr_valid   (jr_valid),
        .jr_target  (jr_target),
        .sel_tgt    (sel_tgt),
        .sel_src    (sel_src),
        .misalign   (misalign)
    );

    // While holding an EX redirect, a new ID jump is on the wrong path and is dropped.
    always_comb begin
        take_new = (sel_src == SRC_BR) || (sel_src == SRC_JR) ||
                   ((sel_src == SRC_JMP) && (pend_src == SRC_JMP));
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc_q;
        pend_tgt_n = pend_tgt;
        pend_src_n = pend_src;
        apply      = 1'b0;
        case (state)
            RUN: begin
                if (sel_src == SRC_NONE) begin
                    if (!stall) pc_n = pc_q + 32'd4;
                end else if (!stall) begin
                    pc_n  = sel_tgt;
                    apply = 1'b1;
                end else begin
                    pend_tgt_n = sel_tgt;
                    pend_src_n = sel_src;
                    state_n    = HOLD;
                end
            end
            HOLD: begin
                if (stall) begin
                    if (take_new) begin
                        pend_tgt_n = sel_tgt;
                        pend_src_n = sel_src;
                    end
                end else begin
                    pc_n       = take_new ? sel_tgt : pend_tgt;
                    apply      = 1'b1;
                    pend_tgt_n = '0;
                    pend_src_n = SRC_NONE;
                    state_n    = RUN;
                end
            end
            default: begin
                state_n    = RUN;
                pend_tgt_n = '0;
                pend_src_n = SRC_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            pc_q      <= RESET_PC;
            pend_tgt  <= '0;
            pend_src  <= SRC_NONE;
            pending_q <= 1'b0;
            flush_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state     <= state_n;
            pc_q      <= pc_n;
            pend_tgt  <= pend_tgt_n;
            pend_src  <= pend_src_n;
            pending_q <= (state_n == HOLD);
            flush_q   <= apply;
            err_q     <= misalign;
            if (apply && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign pc        = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign flush     = flush_q;
    assign pending   = pending_q;
    assign addr_err  = err_q;
    assign redir_cnt = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed plus randomized bench for pc_redirect_unit against a behavioural
// model of fetch-address steering.
module tb_pc_redirect_unit;

    localparam int unsigned CW      = 4;
    localparam logic [31:0] RST_PC  = 32'h0000_3000;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, stall, jmp_valid, br_valid, jr_valid;
    logic [25:0]   jmp_index;
    logic [3:0]    jmp_pc4_hi;
    logic [31:0]   br_target, jr_target;
    logic [31:0]   pc, pc_plus4;
    logic          flush, pending, addr_err;
    logic [CW-1:0] redir_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: a "holding" flag plus the remembered target and
    // whether it came from EX (branch/JR) or ID (jump).
    logic [31:0] m_pc;
    bit          m_hold;
    logic [31:0] m_ptgt;
    bit          m_pex;
    bit          m_flush, m_err;
    int          m_cnt;

    pc_redirect_unit #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .jmp_valid  (jmp_valid),
        .jmp_index  (jmp_index),
        .jmp_pc4_hi (jmp_pc4_hi),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .jr_valid   (jr_valid),
        .jr_target  (jr_target),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .flush      (flush),
        .pending    (pending),
        .addr_err   (addr_err),
        .redir_cnt  (redir_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit          req, ex;
        logic [31:0] tgt;
        bit          do_apply;
        if (rst) begin
            m_pc = RST_PC; m_hold = 0; m_ptgt = '0; m_pex = 0;
            m_flush = 0; m_err = 0; m_cnt = 0;
            return;
        end
        req = 1; ex = 1; tgt = '0;
        if (jr_valid)       tgt = jr_target & 32'hFFFF_FFFC;
        else if (br_valid)  tgt = br_target;
        else if (jmp_valid) begin
            tgt = (32'(jmp_pc4_hi) << 28) + (32'(jmp_index) * 4);
            ex  = 0;
        end else req = 0;
        m_err    = jr_valid && (jr_target % 4 != 0);
        do_apply = 0;
        if (!m_hold) begin
            if (!req) begin
                if (!stall) m_pc = m_pc + 4;
            end else if (!stall) begin
                m_pc = tgt; do_apply = 1;
            end else begin
                m_hold = 1; m_ptgt = tgt; m_pex = ex;
            end
        end else begin
            bit usable = req && (ex || !m_pex);
            if (stall) begin
                if (usable) begin m_ptgt = tgt; m_pex = ex; end
            end else begin
                m_pc = usable ? tgt : m_ptgt;
                m_hold = 0; do_apply = 1;
            end
        end
        m_flush = do_apply;
        if (do_apply && m_cnt < CNT_MAX) m_cnt++;
    endtask

    task automatic cyc(input bit r, input bit s,
                       input bit jv, input logic [25:0] ji, input logic [3:0] jh,
                       input bit bv, input logic [31:0] bt,
                       input bit rv, input logic [31:0] rt);
        rst = r; stall = s;
        jmp_valid = jv; jmp_index = ji; jmp_pc4_hi = jh;
        br_valid = bv; br_target = bt;
        jr_valid = rv; jr_target = rt;
        @(posedge clk);
        model_edge();
        #1;
        chk("pc",        pc,               m_pc);
        chk("pc_plus4",  pc_plus4,         m_pc + 32'd4);
        chk("flush",     32'(flush),       32'(m_flush));
        chk("pending",   32'(pending),     32'(m_hold));
        chk("addr_err",  32'(addr_err),    32'(m_err));
        chk("redir_cnt", 32'(redir_cnt),   32'(m_cnt));
    endtask

    task automatic idle(input bit s);
        cyc(0, s, 0, '0, '0, 0, '0, 0, '0);
    endtask

    initial begin
        rst = 1; stall = 0; jmp_valid = 0; br_valid = 0; jr_valid = 0;
        jmp_index = '0; jmp_pc4_hi = '0; br_target = '0; jr_target = '0;
        m_pc = '0; m_hold = 0; m_ptgt = '0; m_pex = 0; m_flush = 0; m_err = 0; m_cnt = 0;

        // 1: reset then sequential fetch
        cyc(1, 0, 0, '0, '0, 0, '0, 0, '0);
        chk("t1_reset_pc", pc, 32'h0000_3000);
        idle(0); idle(0); idle(0);
        chk("t1_pc", pc, 32'h0000_300C);
        chk("t1_cnt", 32'(redir_cnt), 32'd0);

        // 2: J/JAL
        cyc(0, 0, 1, 26'h0000400, 4'h0, 0, '0, 0, '0);
        chk("t2_pc", pc, 32'h0000_1000);
        chk("t2_flush", 32'(flush), 32'd1);
        chk("t2_cnt", 32'(redir_cnt), 32'd1);
        idle(0);
        chk("t2_flush_off", 32'(flush), 32'd0);

        // 3: branch beats jump
        cyc(0, 0, 1, 26'h10, 4'h0, 1, 32'h0000_2000, 0, '0);
        chk("t3_pc", pc, 32'h0000_2000);
        idle(0);

        // 4: stalled misaligned JR
        cyc(0, 1, 0, '0, '0, 0, '0, 1, 32'h0000_5003);
        chk("t4_hold_pc", pc, 32'h0000_2004);
        chk("t4_pending", 32'(pending), 32'd1);
        chk("t4_err", 32'(addr_err), 32'd1);
        idle(1);
        chk("t4_err_off", 32'(addr_err), 32'd0);
        idle(0);
        chk("t4_pc", pc, 32'h0000_5000);
        chk("t4_flush", 32'(flush), 32'd1);
        chk("t4_pending_off", 32'(pending), 32'd0);

        // 5: pending branch ignores younger jumps
        cyc(0, 1, 0, '0, '0, 1, 32'h0000_4000, 0, '0);
        cyc(0, 1, 1, 26'h123, 4'h0, 0, '0, 0, '0);
        cyc(0, 0, 1, 26'h55, 4'h0, 0, '0, 0, '0);
        chk("t5_pc", pc, 32'h0000_4000);

        // 6: wrap, then reset during HOLD
        cyc(0, 0, 0, '0, '0, 0, '0, 1, 32'hFFFF_FFFC);
        idle(0);
        chk("t6_wrap", pc, 32'h0000_0000);
        cyc(0, 1, 0, '0, '0, 1, 32'h0000_7000, 0, '0);
        cyc(1, 1, 0, '0, '0, 0, '0, 0, '0);
        chk("t6_rst_pc", pc, RST_PC);
        chk("t6_rst_pending", 32'(pending), 32'd0);
        idle(0);
        chk("t6_no_flush", 32'(flush), 32'd0);

        // randomized traffic; small counter width exercises saturation
        for (int unsigned i = 0; i < 500; i++) begin
            logic [31:0] rt;
            rt = $urandom;
            if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
            cyc($urandom_range(0, 99) < 2,
                $urandom_range(0, 99) < 40,
                $urandom_range(0, 99) < 25, 26'($urandom), 4'($urandom),
                $urandom_range(0, 99) < 15, $urandom,
                $urandom_range(0, 99) < 10, rt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
